// File: rtl/pipe_trace_if.sv
// Trace capture / drain bus between the ID-stage tap, debug host and trace buffer.
interface pipe_trace_if #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic              trc_en;
    logic              trc_valid;
    logic [PC_W-1:0]   trc_pc;
    logic [31:0]       trc_instr;
    logic [DATA_W-1:0] trc_wd;
    logic              mode;
    logic              rd_req;
    logic              rd_valid;
    logic [PC_W-1:0]   rd_pc;
    logic [31:0]       rd_instr;
    logic [DATA_W-1:0] rd_wd;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              clr;
    logic [3:0]        cnt_sel;
    logic [CNT_W-1:0]  cnt_out;

    modport master (
        output trc_en, trc_valid, trc_pc, trc_instr, trc_wd, mode, rd_req, clr, cnt_sel,
        input  rd_valid, rd_pc, rd_instr, rd_wd, level, full, empty, overflow, cnt_out
    );

    modport slave (
        input  trc_en, trc_valid, trc_pc, trc_instr, trc_wd, mode, rd_req, clr, cnt_sel,
        output rd_valid, rd_pc, rd_instr, rd_wd, level, full, empty, overflow, cnt_out
    );
endinterface

// File: rtl/pipe_trace_buffer.sv
// Circular instruction trace buffer with stop/wrap modes and per-class counters.
module pipe_trace_buffer #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input logic        clk,
    input logic        rst,
    pipe_trace_if.slave t
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;
    localparam int unsigned ENT_W = PC_W + 32 + DATA_W;
    localparam int unsigned NCLS  = 16;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [LVL_W-1:0] lvl;
    logic [LVL_W-1:0] lvl_nxt_c;
    logic             full_q;
    logic             empty_q;
    logic             ovf_q;
    logic             rd_valid_q;
    logic [ENT_W-1:0] rd_ent_q;
    logic [CNT_W-1:0] cnt [NCLS];

    logic       push_c;
    logic       pop_c;
    logic       full_c;
    logic       wr_c;
    logic       ovf_c;
    logic [5:0] op_c;
    logic [5:0] fn_c;
    logic [3:0] cls_c;

    assign push_c = t.trc_en & t.trc_valid;
    assign full_c = (lvl == LVL_W'(DEPTH));
    assign pop_c  = t.rd_req & (lvl != '0);
    // A push is written unless it hits a full buffer in stop mode with no pop to make room.
    assign wr_c   = push_c & (~full_c | pop_c | t.mode);
    assign ovf_c  = push_c & full_c & ~pop_c;
    assign op_c   = t.trc_instr[31:26];
    assign fn_c   = t.trc_instr[5:0];

    // Instruction class decode of the ID-stage word.
    always_comb begin
        cls_c = 4'd14;
        if (t.trc_instr == 32'd0) begin
            cls_c = 4'd0;
        end else if (op_c == 6'd0) begin
            case (fn_c)
                6'd32:   cls_c = 4'd1;
                6'd34:   cls_c = 4'd2;
                6'd36:   cls_c = 4'd3;
                6'd37:   cls_c = 4'd4;
                6'd2:    cls_c = 4'd5;
                6'd25:   cls_c = 4'd6;
                6'd16:   cls_c = 4'd7;
                6'd18:   cls_c = 4'd8;
                default: cls_c = 4'd14;
            endcase
        end else begin
            case (op_c)
                6'd9:    cls_c = 4'd9;
                6'd35:   cls_c = 4'd10;
                6'd43:   cls_c = 4'd11;
                6'd4:    cls_c = 4'd12;
                6'd2:    cls_c = 4'd13;
                default: cls_c = 4'd14;
            endcase
        end
    end

    // Next occupancy: a dropped or wrapped push on full leaves it at DEPTH.
    always_comb begin
        lvl_nxt_c = lvl;
        if (push_c && !full_c && !pop_c) begin
            lvl_nxt_c = lvl + LVL_W'(1);
        end else if (pop_c && !push_c) begin
            lvl_nxt_c = lvl - LVL_W'(1);
        end
    end

    // Entry storage; not reset, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem[wp] <= {t.trc_pc, t.trc_instr, t.trc_wd};
        end
    end

    // Pointers, occupancy flags, overflow and the registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp         <= '0;
            rp         <= '0;
            lvl        <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_ent_q   <= '0;
        end else begin
            if (wr_c) begin
                wp <= wp + AW'(1);
            end
            if (pop_c || (ovf_c && t.mode)) begin
                rp <= rp + AW'(1);
            end
            lvl     <= lvl_nxt_c;
            full_q  <= (lvl_nxt_c == LVL_W'(DEPTH));
            empty_q <= (lvl_nxt_c == '0);
            if (t.clr) begin
                ovf_q <= 1'b0;
            end else if (ovf_c) begin
                ovf_q <= 1'b1;
            end
            rd_valid_q <= pop_c;
            if (pop_c) begin
                rd_ent_q <= mem[rp];
            end
        end
    end

    // Saturating class counters; slot 15 counts every push, dropped ones included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCLS; i++) cnt[i] <= '0;
        end else if (t.clr) begin
            for (int i = 0; i < NCLS; i++) cnt[i] <= '0;
        end else if (push_c) begin
            for (int i = 0; i < NCLS; i++) begin
                if ((4'(i) == cls_c || i == NCLS - 1) && cnt[i] != '1) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign t.rd_valid = rd_valid_q;
    assign t.rd_pc    = rd_ent_q[ENT_W-1 -: PC_W];
    assign t.rd_instr = rd_ent_q[DATA_W +: 32];
    assign t.rd_wd    = rd_ent_q[DATA_W-1:0];
    assign t.level    = lvl;
    assign t.full     = full_q;
    assign t.empty    = empty_q;
    assign t.overflow = ovf_q;
    assign t.cnt_out  = cnt[t.cnt_sel];
endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Bench for pipe_trace_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_pipe_trace_buffer;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_trace_if #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(16)) m ();
    pipe_trace_if #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(4))  s ();

    pipe_trace_buffer #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .t(m)
    );
    pipe_trace_buffer #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .t(s)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wd;
    } ent_t;

    // Reference model: FIFO of stored entries, class tallies, sticky overflow.
    ent_t        mq[$];
    int unsigned mcnt[16];
    bit          movf;
    bit          exp_rdv;
    ent_t        exp_rd;
    int          n_cmp  = 0;
    int          n_fail = 0;

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < 16; i++) mcnt[i] = 0;
        movf    = 1'b0;
        exp_rdv = 1'b0;
        exp_rd  = '{32'd0, 32'd0, 32'd0};
    endfunction

    // Build an instruction word of a chosen class with random don't-care fields.
    function automatic logic [31:0] gen_instr(input int cls);
        logic [19:0] mid;
        logic [25:0] low;
        mid = 20'($urandom);
        low = 26'($urandom);
        case (cls)
            0:  return 32'd0;
            1:  return {6'd0, mid, 6'd32};
            2:  return {6'd0, mid, 6'd34};
            3:  return {6'd0, mid, 6'd36};
            4:  return {6'd0, mid, 6'd37};
            5:  return {6'd0, mid, 6'd2};
            6:  return {6'd0, mid, 6'd25};
            7:  return {6'd0, mid, 6'd16};
            8:  return {6'd0, mid, 6'd18};
            9:  return {6'd9, low};
            10: return {6'd35, low};
            11: return {6'd43, low};
            12: return {6'd4, low};
            13: return {6'd2, low};
            default: begin
                case ($urandom_range(0, 2))
                    0:       return {6'd13, low};
                    1:       return {6'd0, mid, 6'd33};
                    default: return {6'd0, 20'h00040, 6'd0};
                endcase
            end
        endcase
    endfunction

    // One clock: drive inputs, advance the model at the edge, settle after it.
    task automatic cycle(input bit en, input bit vld, input int cls, input logic [31:0] pc,
                         input logic [31:0] wd, input bit rd, input bit clr_i);
        logic [31:0] instr;
        bit push;
        bit pop;
        instr       = gen_instr(cls);
        m.trc_en    = en;
        m.trc_valid = vld;
        m.trc_pc    = pc;
        m.trc_instr = instr;
        m.trc_wd    = wd;
        m.rd_req    = rd;
        m.clr       = clr_i;
        @(posedge clk);
        push = en && vld;
        pop  = rd && (mq.size() > 0);
        if (pop) exp_rd = mq[0];
        exp_rdv = pop;
        if (push) begin
            if (mcnt[cls] < 65535) mcnt[cls]++;
            if (mcnt[15] < 65535) mcnt[15]++;
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) begin
                mq.push_back('{pc, instr, wd});
            end else if (m.mode == 1'b0) begin
                movf = 1'b1;
            end else begin
                void'(mq.pop_front());
                mq.push_back('{pc, instr, wd});
                movf = 1'b1;
            end
        end
        if (clr_i) begin
            for (int i = 0; i < 16; i++) mcnt[i] = 0;
            movf = 1'b0;
        end
        #1;
        m.trc_en = 1'b0; m.trc_valid = 1'b0; m.rd_req = 1'b0; m.clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m.trc_en = 0; m.trc_valid = 0; m.trc_pc = 0; m.trc_instr = 0; m.trc_wd = 0;
        m.mode = 0; m.rd_req = 0; m.clr = 0; m.cnt_sel = 0;
        s.trc_en = 0; s.trc_valid = 0; s.trc_pc = 0; s.trc_instr = 0; s.trc_wd = 0;
        s.mode = 0; s.rd_req = 0; s.clr = 0; s.cnt_sel = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (m.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", m.empty); end
        n_cmp++; if (m.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", m.full); end
        n_cmp++; if (m.level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", m.level); end
        n_cmp++; if (m.rd_valid !== 1'b0 || m.rd_pc !== 32'd0 || m.rd_instr !== 32'd0 || m.rd_wd !== 32'd0) begin
            n_fail++; $display("FAIL reset_rd got v=%b pc=%h want v=0 pc=0", m.rd_valid, m.rd_pc); end
        n_cmp++; if (m.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", m.overflow); end
        m.cnt_sel = 4'd15; #1;
        n_cmp++; if (m.cnt_out !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", m.cnt_out); end
    endtask

    task automatic test_fill();
        m.mode = 1'b0;
        for (int i = 0; i < 16; i++) cycle(1, 1, 1, 32'(i * 4), $urandom, 0, 0);
        n_cmp++; if (m.full !== 1'b1 || m.level !== 5'd16) begin
            n_fail++; $display("FAIL fill_level got full=%b level=%0d want 1/16", m.full, m.level); end
        m.cnt_sel = 4'd1; #1;
        n_cmp++; if (m.cnt_out !== 16'd16) begin n_fail++; $display("FAIL fill_cnt_add got %0d want 16", m.cnt_out); end
        m.cnt_sel = 4'd15; #1;
        n_cmp++; if (m.cnt_out !== 16'd16) begin n_fail++; $display("FAIL fill_cnt_total got %0d want 16", m.cnt_out); end
        n_cmp++; if (m.overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf got %b want 0", m.overflow); end
    endtask

    task automatic test_stop_overflow();
        cycle(1, 1, 10, 32'h40, $urandom, 0, 0);
        n_cmp++; if (m.level !== 5'd16 || m.overflow !== 1'b1) begin
            n_fail++; $display("FAIL stop_ovf got level=%0d ovf=%b want 16/1", m.level, m.overflow); end
        m.cnt_sel = 4'd10; #1;
        n_cmp++; if (m.cnt_out !== 16'd1) begin n_fail++; $display("FAIL stop_cnt_lw got %0d want 1", m.cnt_out); end
        m.cnt_sel = 4'd15; #1;
        n_cmp++; if (m.cnt_out !== 16'd17) begin n_fail++; $display("FAIL stop_cnt_total got %0d want 17", m.cnt_out); end
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 0, 0, 0, 1, 0);
            n_cmp++; if (m.rd_valid !== 1'b1 || m.rd_pc !== 32'(i * 4) || m.rd_instr !== exp_rd.instr || m.rd_wd !== exp_rd.wd) begin
                n_fail++; $display("FAIL stop_drain[%0d] got v=%b pc=%h want v=1 pc=%h", i, m.rd_valid, m.rd_pc, 32'(i * 4)); end
        end
        n_cmp++; if (m.empty !== 1'b1) begin n_fail++; $display("FAIL stop_empty got %b want 1", m.empty); end
    endtask

    task automatic test_wrap();
        cycle(0, 0, 0, 0, 0, 0, 1);
        m.mode = 1'b1;
        for (int i = 0; i < 20; i++) cycle(1, 1, $urandom_range(0, 14), 32'(i * 4), $urandom, 0, 0);
        n_cmp++; if (m.level !== 5'd16 || m.overflow !== 1'b1) begin
            n_fail++; $display("FAIL wrap_level got level=%0d ovf=%b want 16/1", m.level, m.overflow); end
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 0, 0, 0, 1, 0);
            n_cmp++; if (m.rd_valid !== 1'b1 || m.rd_pc !== 32'(32'h10 + i * 4) || m.rd_wd !== exp_rd.wd) begin
                n_fail++; $display("FAIL wrap_drain[%0d] got v=%b pc=%h want v=1 pc=%h", i, m.rd_valid, m.rd_pc, 32'(32'h10 + i * 4)); end
        end
        n_cmp++; if (m.empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b want 1", m.empty); end
        m.mode = 1'b0;
    endtask

    task automatic test_simultaneous();
        cycle(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 1, 3, 32'(32'h100 + i * 4), $urandom, 0, 0);
        cycle(1, 1, 4, 32'h200, $urandom, 1, 0);
        n_cmp++; if (m.level !== 5'd3 || m.rd_valid !== 1'b1 || m.rd_pc !== 32'h100) begin
            n_fail++; $display("FAIL simul got level=%0d v=%b pc=%h want 3/1/100", m.level, m.rd_valid, m.rd_pc); end
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1, 0);
        n_cmp++; if (m.rd_pc !== 32'h200 || m.empty !== 1'b1) begin
            n_fail++; $display("FAIL simul_drain got pc=%h empty=%b want 200/1", m.rd_pc, m.empty); end
        cycle(0, 0, 0, 0, 0, 1, 0);
        n_cmp++; if (m.rd_valid !== 1'b0 || m.level !== 5'd0 || m.rd_pc !== 32'h200) begin
            n_fail++; $display("FAIL rd_empty got v=%b level=%0d pc=%h want 0/0/200", m.rd_valid, m.level, m.rd_pc); end
        cycle(1, 1, 5, 32'h300, $urandom, 1, 0);
        n_cmp++; if (m.rd_valid !== 1'b0 || m.level !== 5'd1) begin
            n_fail++; $display("FAIL push_rd_at_empty got v=%b level=%0d want 0/1", m.rd_valid, m.level); end
        cycle(0, 0, 0, 0, 0, 1, 0);
        n_cmp++; if (m.rd_valid !== 1'b1 || m.rd_pc !== 32'h300) begin
            n_fail++; $display("FAIL push_rd_pop got v=%b pc=%h want 1/300", m.rd_valid, m.rd_pc); end
    endtask

    task automatic test_random();
        int pp;
        int rp;
        for (int c = 0; c < 400; c++) begin
            pp = ((c / 50) % 2 == 0) ? 80 : 30;
            rp = 110 - pp;
            if ($urandom_range(0, 19) == 0) m.mode = ~m.mode;
            m.cnt_sel = 4'($urandom);
            cycle($urandom_range(0, 99) < pp + 10, $urandom_range(0, 99) < 90 ? 1'b1 : 1'b0,
                  $urandom_range(0, 14), $urandom, $urandom,
                  $urandom_range(0, 99) < rp, $urandom_range(0, 39) == 0);
            n_cmp++; if (m.rd_valid !== exp_rdv || m.rd_pc !== exp_rd.pc || m.rd_instr !== exp_rd.instr || m.rd_wd !== exp_rd.wd) begin
                n_fail++; $display("FAIL rand_rd[%0d] got v=%b pc=%h ins=%h want v=%b pc=%h ins=%h",
                                   c, m.rd_valid, m.rd_pc, m.rd_instr, exp_rdv, exp_rd.pc, exp_rd.instr); end
            n_cmp++; if (m.level !== 5'(mq.size()) || m.full !== (mq.size() == DEPTH) || m.empty !== (mq.size() == 0)) begin
                n_fail++; $display("FAIL rand_level[%0d] got %0d f=%b e=%b want %0d", c, m.level, m.full, m.empty, mq.size()); end
            n_cmp++; if (m.overflow !== movf) begin
                n_fail++; $display("FAIL rand_ovf[%0d] got %b want %b", c, m.overflow, movf); end
            n_cmp++; if (m.cnt_out !== 16'(mcnt[m.cnt_sel])) begin
                n_fail++; $display("FAIL rand_cnt[%0d] sel %0d got %0d want %0d", c, m.cnt_sel, m.cnt_out, mcnt[m.cnt_sel]); end
        end
        m.mode = 1'b0;
    endtask

    task automatic test_saturation();
        s.mode = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s.trc_en = 1; s.trc_valid = 1; s.trc_instr = 32'd0; s.trc_pc = 32'(i * 4); s.trc_wd = $urandom;
            @(posedge clk); #1;
        end
        s.trc_en = 0; s.trc_valid = 0;
        s.cnt_sel = 4'd0; #1;
        n_cmp++; if (s.cnt_out !== 4'd15) begin n_fail++; $display("FAIL sat_nop got %0d want 15", s.cnt_out); end
        s.cnt_sel = 4'd15; #1;
        n_cmp++; if (s.cnt_out !== 4'd15) begin n_fail++; $display("FAIL sat_total got %0d want 15", s.cnt_out); end
        n_cmp++; if (s.overflow !== 1'b1 || s.level !== 5'd16) begin
            n_fail++; $display("FAIL sat_ovf got ovf=%b level=%0d want 1/16", s.overflow, s.level); end
        s.trc_en = 1; s.trc_valid = 1; s.clr = 1;
        @(posedge clk); #1;
        s.trc_en = 0; s.trc_valid = 0; s.clr = 0;
        s.cnt_sel = 4'd0; #1;
        n_cmp++; if (s.cnt_out !== 4'd0 || s.overflow !== 1'b0) begin
            n_fail++; $display("FAIL sat_clr got cnt=%0d ovf=%b want 0/0", s.cnt_out, s.overflow); end
        n_cmp++; if (s.level !== 5'd16) begin n_fail++; $display("FAIL sat_clr_level got %0d want 16", s.level); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cycle(1, 1, $urandom_range(0, 14), $urandom, $urandom, 0, 0);
        m.rd_req = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (m.rd_valid !== 1'b0 || m.empty !== 1'b1 || m.level !== 5'd0) begin
            n_fail++; $display("FAIL rst_mid got v=%b e=%b level=%0d want 0/1/0", m.rd_valid, m.empty, m.level); end
        for (int i = 0; i < 16; i++) begin
            m.cnt_sel = 4'(i); #1;
            n_cmp++; if (m.cnt_out !== 16'd0) begin n_fail++; $display("FAIL rst_mid_cnt[%0d] got %0d want 0", i, m.cnt_out); end
        end
        @(posedge clk); #1;
        n_cmp++; if (m.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_edge got %b want 0", m.rd_valid); end
        rst = 1'b0; m.rd_req = 1'b0;
        model_reset();
        cycle(0, 0, 0, 0, 0, 1, 0);
        n_cmp++; if (m.rd_valid !== 1'b0 || m.empty !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_after got v=%b e=%b want 0/1", m.rd_valid, m.empty); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stop_overflow();
        test_wrap();
        test_simultaneous();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
